// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO input conditioner:
//   - deb_state_e : per-channel debounce FSM state encoding
//   - cnt_width() : width of the debounce counter for a given
//                   DEBOUNCE_CYCLES (never less than 1 bit)
package gpio_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } deb_state_e;

  // clog2(cycles) bits hold the largest count value cycles-1; a
  // DEBOUNCE_CYCLES of 1 still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
// One GPIO input channel: two-flop synchronizer followed by a
// four-state debounce FSM with a saturating stability counter.
// Ports:
//   clk     in  : clock, all state updates on rising edge
//   reset   in  : synchronous active-high reset
//   pad_in  in  : raw asynchronous pad level
//   pin_out out : debounced level (1 in STABLE_HI / WAIT_LO)
//   rise    out : one-cycle pulse on accepted 0->1 transition
//   fall    out : one-cycle pulse on accepted 1->0 transition
module debounce_channel
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic clk,
  input  logic reset,
  input  logic pad_in,
  output logic pin_out,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_q;
  logic             sync2_q;
  deb_state_e       state_q;
  deb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             rise_q;
  logic             rise_d;
  logic             fall_q;
  logic             fall_d;

  // Two-flop synchronizer for the asynchronous pad level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_in;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state logic. A WAIT state is left either on a
  // glitch (back to the old stable level, no pulse) or once the
  // counter has reached DEBOUNCE_CYCLES-1, so it can never wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = STABLE_LO;
        end
      end
      WAIT_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = STABLE_HI;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, counter and edge-pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STABLE_LO;
      cnt_q   <= CNT_ZERO;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The debounced level is a pure decode of the registered state, so
  // it changes on the same edge that raises rise/fall.
  assign pin_out = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner
// WIDTH-channel GPIO input conditioner: per-channel synchronizer and
// debouncer, edge pulses, and sticky edge-event interrupt flags.
// Ports:
//   clk         in  : clock
//   reset       in  : synchronous active-high reset
//   pad_in      in  : raw pad levels [WIDTH]
//   pin_out     out : debounced levels [WIDTH]
//   rise / fall out : one-cycle accepted-edge pulses [WIDTH]
//   rise_en     in  : latch rise events into irq_pending [WIDTH]
//   fall_en     in  : latch fall events into irq_pending [WIDTH]
//   irq_clr     in  : write-1-to-clear for irq_pending [WIDTH]
//   irq_pending out : sticky event flags [WIDTH]
//   irq         out : OR of irq_pending
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 48000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  logic [WIDTH-1:0] irq_pending_q;
  logic [WIDTH-1:0] irq_pending_d;
  logic [WIDTH-1:0] irq_set_s;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .pad_in (pad_in[g]),
      .pin_out(pin_out[g]),
      .rise   (rise[g]),
      .fall   (fall[g])
    );
  end

  // Set is applied after clear so a coincident set keeps the bit.
  always_comb begin
    irq_set_s     = (rise & rise_en) | (fall & fall_en);
    irq_pending_d = (irq_pending_q & ~irq_clr) | irq_set_s;
  end

  // Sticky interrupt flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pending_q <= {WIDTH{1'b0}};
    end else begin
      irq_pending_q <= irq_pending_d;
    end
  end

  assign irq_pending = irq_pending_q;
  assign irq         = |irq_pending_q;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
module tb_gpio_in_conditioner;

  localparam int W  = 8;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pad_in, rise_en, fall_en, irq_clr;
  logic [W-1:0] pin_out, rise, fall, irq_pending;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  gpio_in_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .pad_in(pad_in), .pin_out(pin_out),
    .rise(rise), .fall(fall), .rise_en(rise_en), .fall_en(fall_en),
    .irq_clr(irq_clr), .irq_pending(irq_pending), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a channel's sampled level is pad_in delayed by two
  // edges; the output level adopts that sample once the sample has
  // disagreed with it for DC+1 consecutive edges.
  logic [W-1:0] m_s1, m_s2, m_pin, m_rise, m_fall, m_pend;
  logic [W-1:0] n_s1, n_s2, n_pin, n_rise, n_fall, n_pend;
  int m_run [W];
  int n_run [W];

  always_comb begin
    n_s1   = pad_in;
    n_s2   = m_s1;
    n_pin  = m_pin;
    n_rise = '0;
    n_fall = '0;
    n_run  = m_run;
    n_pend = (m_pend & ~irq_clr) | (m_rise & rise_en) | (m_fall & fall_en);
    for (int i = 0; i < W; i++) begin
      if (m_s2[i] != m_pin[i]) begin
        if (m_run[i] + 1 == DC + 1) begin
          n_pin[i]  = m_s2[i];
          n_rise[i] = m_s2[i];
          n_fall[i] = ~m_s2[i];
          n_run[i]  = 0;
        end else begin
          n_run[i] = m_run[i] + 1;
        end
      end else begin
        n_run[i] = 0;
      end
    end
    if (reset) begin
      n_s1 = '0; n_s2 = '0; n_pin = '0; n_rise = '0; n_fall = '0; n_pend = '0;
      for (int i = 0; i < W; i++) n_run[i] = 0;
    end
  end

  always @(posedge clk) begin
    m_s1 <= n_s1; m_s2 <= n_s2; m_pin <= n_pin;
    m_rise <= n_rise; m_fall <= n_fall; m_pend <= n_pend;
    m_run <= n_run;
  end

  task automatic test_reset();
    reset = 1'b1; pad_in = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_tests++;
      if ({pin_out, rise, fall, irq_pending, irq} !== 33'h0) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: got pin=%h rise=%h fall=%h pend=%h irq=%b, expected all 0",
                 c, pin_out, rise, fall, irq_pending, irq);
      end
    end
  endtask

  task automatic test_rise();
    pad_in = 8'h01;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if (pin_out !== 8'h00 || rise !== 8'h00) begin
        n_fail++;
        $display("FAIL rise_early cyc%0d: got pin=%h rise=%h, expected 00 00", c, pin_out, rise);
      end
    end
    @(negedge clk);
    n_tests++;
    if (pin_out !== 8'h01 || rise !== 8'h01 || fall !== 8'h00) begin
      n_fail++;
      $display("FAIL rise_accept: got pin=%h rise=%h fall=%h, expected 01 01 00", pin_out, rise, fall);
    end
    @(negedge clk);
    n_tests++;
    if (pin_out !== 8'h01 || rise !== 8'h00 || fall !== 8'h00) begin
      n_fail++;
      $display("FAIL rise_one_cycle: got pin=%h rise=%h fall=%h, expected 01 00 00", pin_out, rise, fall);
    end
    pad_in = 8'h00;
    repeat (10) @(negedge clk);
    n_tests++;
    if (pin_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rise_return_low: got pin=%h, expected 00", pin_out);
    end
  endtask

  // Pulses of DC-1 and DC samples are rejected; DC+1 is accepted.
  task automatic test_glitch();
    int lens [3] = '{3, 4, 5};
    logic seen_r, seen_f, seen_other, exp_seen;
    foreach (lens[k]) begin
      seen_r = 1'b0; seen_f = 1'b0; seen_other = 1'b0;
      exp_seen = (lens[k] >= DC + 1);
      pad_in = 8'h08;
      for (int c = 0; c < lens[k] + 18; c++) begin
        @(negedge clk);
        if (c == lens[k] - 1) pad_in = 8'h00;
        seen_r |= rise[3];
        seen_f |= fall[3];
        seen_other |= (|(rise & 8'hF7)) | (|(fall & 8'hF7)) | (|(pin_out & 8'hF7));
      end
      n_tests++;
      if (seen_r !== exp_seen || seen_f !== exp_seen || seen_other !== 1'b0 || pin_out !== 8'h00) begin
        n_fail++;
        $display("FAIL glitch_len%0d: got rise=%b fall=%b other=%b pin=%h, expected rise=%b fall=%b other=0 pin=00",
                 lens[k], seen_r, seen_f, seen_other, pin_out, exp_seen, exp_seen);
      end
    end
  endtask

  task automatic test_irq();
    bit found = 1'b0;
    rise_en = 8'h01; fall_en = 8'h00;
    irq_clr = 8'hFF; @(negedge clk); irq_clr = 8'h00;
    pad_in = 8'h01;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (rise[0]) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL irq_rise_timeout: got no rise[0], expected one within 20 cycles");
    end
    @(negedge clk);
    n_tests++;
    if (irq_pending !== 8'h01 || irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_set: got pend=%h irq=%b, expected 01 1", irq_pending, irq);
    end
    pad_in = 8'h00;
    repeat (12) @(negedge clk);
    n_tests++;
    if (irq_pending !== 8'h01 || pin_out !== 8'h00) begin
      n_fail++;
      $display("FAIL irq_fall_masked: got pend=%h pin=%h, expected 01 00", irq_pending, pin_out);
    end
    irq_clr = 8'h01;
    @(negedge clk);
    irq_clr = 8'h00;
    n_tests++;
    if (irq_pending !== 8'h00 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear: got pend=%h irq=%b, expected 00 0", irq_pending, irq);
    end
  endtask

  task automatic test_set_wins();
    bit found = 1'b0;
    rise_en = 8'h04; fall_en = 8'h00;
    pad_in = 8'h04;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (rise[2]) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL setwins_timeout: got no rise[2], expected one within 20 cycles");
    end
    irq_clr = 8'h04;
    @(negedge clk);
    irq_clr = 8'h00;
    n_tests++;
    if (irq_pending !== 8'h04) begin
      n_fail++;
      $display("FAIL set_wins: got pend=%h, expected 04", irq_pending);
    end
    pad_in = 8'h00;
    repeat (12) @(negedge clk);
    irq_clr = 8'hFF; @(negedge clk); irq_clr = 8'h00;
  endtask

  task automatic test_reset_mid();
    logic any_pulse = 1'b0;
    rise_en = '0; fall_en = '0;
    reset = 1'b1; pad_in = 8'h00; @(negedge clk); reset = 1'b0;
    pad_in = 8'hFF;
    repeat (3) @(negedge clk);   // FSMs now in WAIT_HI
    reset = 1'b1;
    @(negedge clk);
    any_pulse |= (|rise) | (|pin_out);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      any_pulse |= (|rise) | (|pin_out);
    end
    n_tests++;
    if (any_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got early pulse/pin=%b, expected 0", any_pulse);
    end
    @(negedge clk);
    n_tests++;
    if (pin_out !== 8'hFF || rise !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_mid_rise: got pin=%h rise=%h, expected FF FF", pin_out, rise);
    end
    @(negedge clk);
    n_tests++;
    if (rise !== 8'h00 || pin_out !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_mid_once: got pin=%h rise=%h, expected FF 00", pin_out, rise);
    end
  endtask

  task automatic test_random();
    reset = 1'b1; pad_in = '0; irq_clr = '0; @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        rise_en = 8'($urandom); fall_en = 8'($urandom);
      end
      for (int b = 0; b < W; b++) begin
        if ($urandom_range(5, 0) == 0) pad_in[b] = ~pad_in[b];
        irq_clr[b] = ($urandom_range(7, 0) == 0);
      end
      if (c == 400) reset = 1'b1;
      if (c == 401) reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({pin_out, rise, fall, irq_pending, irq} !== {m_pin, m_rise, m_fall, m_pend, |m_pend}) begin
        n_fail++;
        $display("FAIL random cyc%0d: got pin=%h rise=%h fall=%h pend=%h irq=%b, expected %h %h %h %h %b",
                 c, pin_out, rise, fall, irq_pending, irq, m_pin, m_rise, m_fall, m_pend, |m_pend);
      end
    end
    irq_clr = '0;
  endtask

  initial begin
    reset = 1'b1; pad_in = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
    test_reset();
    test_rise();
    test_glitch();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
